// File: rtl/ext_out_uart_tx.sv
// ext_out_uart_tx: queues CPU ext_out bytes in a small FIFO and sends them as 8N1 UART frames
module ext_out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    din,
  input  logic                          din_we,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic full_q, full_d, overflow_q, overflow_d, busy_q, busy_d, tx_q, tx_d;
  logic wr, pop, last;
  always_comb begin
    wr = din_we && !full_q;
    last = clk_cnt_q == CW'(CLKS_PER_BIT - 1);
    pop = (count_q != '0) && (state_q == IDLE || (state_q == STOP && last));
    state_d = state_q;
    clk_cnt_d = last ? '0 : clk_cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        state_d = pop ? START : IDLE;
      end
      START: state_d = last ? DATA : START;
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        bit_idx_d = bit_idx_q + 3'd1;
        state_d = (bit_idx_q == 3'd7) ? STOP : DATA;
      end
      default: state_d = last ? (pop ? START : IDLE) : STOP;
    endcase
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      bit_idx_d = '0;
    end
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(wr);
    count_d = count_q + NW'(wr) - NW'(pop);
    full_d = count_d == NW'(FIFO_DEPTH);
    overflow_d = overflow_q || (din_we && full_q);
    busy_d = (state_d != IDLE) || (count_d != '0);
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q <= shift_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      overflow_q <= overflow_d;
      busy_q <= busy_d;
      tx_q <= tx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !rst) mem_q[wr_ptr_q] <= din;
  end
  assign tx = tx_q;
  assign busy = busy_q;
  assign full = full_q;
  assign overflow = overflow_q;
  assign fifo_count = count_q;
endmodule
